// File: rtl/fifo_arb_pkg.sv
// Shared definitions for the fast_fifo write-side arbiter and its rotating-priority picker.
package fifo_arb_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_BURST = 1'b1
  } state_e;

  localparam int DEFAULT_MAX_BURST = 4;
  localparam int MAX_NREQ          = 8;

  // Index of the set bit; callers guarantee at most one bit is set.
  function automatic logic [2:0] onehot_to_idx(input logic [MAX_NREQ-1:0] oh);
    logic [2:0] idx;
    idx = '0;
    for (int i = 0; i < MAX_NREQ; i++) begin
      if (oh[i]) idx = idx | 3'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational rotating-priority selector: first asserted req scanning last+1, last+2, ... mod NREQ.
module rr_pick #(
  parameter int NREQ = 4,
  parameter int IW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   last,
  output logic            valid,
  output logic [IW-1:0]   sel
);

  always_comb begin
    logic [IW-1:0] cand;
    // NOTE: every output and temporary gets a default first so no path leaves one unassigned (no latch).
    valid = 1'b0;
    sel   = '0;
    cand  = '0;
    for (int k = 1; k <= NREQ; k++) begin
      cand = IW'((int'(last) + k) % NREQ);
      if (!valid && req[cand]) begin
        valid = 1'b1;
        sel   = cand;
      end
    end
  end

endmodule

// File: rtl/fifo_write_arbiter.sv
// Round-robin arbiter sharing the fast_fifo write port among NREQ requesters in bounded bursts.
// Optional per-requester stall counters are enabled with FIFO_ARB_STATS_EN.
module fifo_write_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int NREQ      = 4,
  parameter int W_SIZE    = 32,
  parameter int MAX_BURST = DEFAULT_MAX_BURST,
  parameter int BCW       = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NREQ-1:0]          req,
  input  logic [NREQ*W_SIZE-1:0]   wdata_in,
  input  logic                     full,
  output logic [NREQ-1:0]          gnt,
  output logic                     count,
  output logic [W_SIZE-1:0]        wdata,
  output logic [NREQ-1:0]          ack,
  output logic                     busy
`ifdef FIFO_ARB_STATS_EN
  ,
  input  logic                     stats_clr,
  output logic [NREQ*16-1:0]       stall_cnt
`endif
);

  localparam int IW = $clog2(NREQ);

  state_e          state_q, state_d;
  logic [NREQ-1:0] gnt_q, gnt_d;
  logic [BCW-1:0]  beat_q, beat_d;
  logic [IW-1:0]   last_q, last_d;

  logic            pick_valid;
  logic [IW-1:0]   pick_sel;
  logic [IW-1:0]   owner;
  logic            req_o;

  rr_pick #(.NREQ(NREQ), .IW(IW)) u_pick (
    .req   (req),
    .last  (last_q),
    .valid (pick_valid),
    .sel   (pick_sel)
  );

  assign owner = IW'(onehot_to_idx(MAX_NREQ'(gnt_q)));
  assign req_o = req[owner];
  assign gnt   = gnt_q;

  // Strobe and data mux act on the registered grant, so a full stall never drops a word.
  always_comb begin
    busy  = (state_q == ST_BURST);
    count = busy & req_o & ~full;
    ack   = gnt_q & {NREQ{count}};
    wdata = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt_q[i]) wdata = wdata_in[i*W_SIZE +: W_SIZE];
    end
  end

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    beat_d  = beat_q;
    last_d  = last_q;
    case (state_q)
      ST_IDLE: begin
        if (pick_valid && !full) begin
          state_d = ST_BURST;
          gnt_d   = NREQ'(1) << pick_sel;
          last_d  = pick_sel;
          beat_d  = '0;
        end
      end
      ST_BURST: begin
        if (count) beat_d = beat_q + BCW'(1);
        if (!req_o || (count && beat_q == BCW'(MAX_BURST - 1))) begin
          state_d = ST_IDLE;
          gnt_d   = '0;
          beat_d  = '0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      gnt_q   <= '0;
      beat_q  <= '0;
      last_q  <= IW'(NREQ - 1);
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values regardless of order.
      state_q <= state_d;
      gnt_q   <= gnt_d;
      beat_q  <= beat_d;
      last_q  <= last_d;
    end
  end

`ifdef FIFO_ARB_STATS_EN
  logic [15:0] stall_q [NREQ];
  logic [15:0] stall_d [NREQ];

  always_comb begin
    for (int i = 0; i < NREQ; i++) begin
      stall_d[i] = stall_q[i];
      if (stats_clr) stall_d[i] = '0;
      else if (req[i] && !ack[i] && stall_q[i] != 16'hFFFF) stall_d[i] = stall_q[i] + 16'd1;
    end
  end

  // Only NREQ small counters, so they take the async reset like any other state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREQ; i++) stall_q[i] <= '0;
    end else begin
      for (int i = 0; i < NREQ; i++) stall_q[i] <= stall_d[i];
    end
  end

  for (genvar g = 0; g < NREQ; g++) begin : g_stall
    assign stall_cnt[g*16 +: 16] = stall_q[g];
  end
`endif

endmodule
